ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register of the RV32I core; sits directly upstream of the ALU and drives its ALUop1, ALUop2 and ALUctrl inputs.
- Captures decoded operands and control each cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, raises a stall request to the front end and inserts a bubble.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, register-file index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1_data  in  DATA_WIDTH  register-file read data, rs1
- id_rs2_data  in  DATA_WIDTH  register-file read data, rs2
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs1_addr  in  ADDR_WIDTH  rs1 index
- id_rs2_addr  in  ADDR_WIDTH  rs2 index
- id_rd_addr  in  ADDR_WIDTH  destination index
- id_alu_ctrl  in  3  ALU operation code
- id_alu_src  in  1  1: ALUop2 = imm; 0: ALUop2 = rs2
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- hold  in  1  downstream freeze; register keeps its contents
- flush  in  1  branch redirect; kill the instruction in EX
- exm_rd_addr  in  ADDR_WIDTH  EX/MEM destination
- exm_reg_write  in  1  EX/MEM writes rd
- exm_result  in  DATA_WIDTH  EX/MEM ALU result
- wb_rd_addr  in  ADDR_WIDTH  MEM/WB destination
- wb_reg_write  in  1  MEM/WB writes rd
- wb_result  in  DATA_WIDTH  MEM/WB writeback value
- ALUop1  out  DATA_WIDTH  ALU operand 1
- ALUop2  out  DATA_WIDTH  ALU operand 2
- ALUctrl  out  3  registered ALU control
- ex_store_data  out  DATA_WIDTH  forwarded rs2, for stores
- ex_rd_addr  out  ADDR_WIDTH  registered destination
- ex_reg_write  out  1  ex_valid AND registered reg_write
- ex_mem_read  out  1  ex_valid AND registered mem_read
- ex_valid  out  1  EX slot holds a live instruction
- stall_req  out  1  front end must hold PC and IF/ID this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it overrides everything.
- Reset state: all registered fields 0, including ex_valid. As a result, after reset:
  - ALUop1 = 0, ALUop2 = 0, ALUctrl = 3'b000
  - ex_store_data = 0, ex_rd_addr = 0
  - ex_reg_write = 0, ex_mem_read = 0, stall_req = 0
- Register update priority at each clock edge:
  1. rst
  2. flush: load a bubble (valid = 0, reg_write = 0, mem_read = 0; data fields don't-care but zeroed)
  3. hold: keep all fields
  4. stall_req: load a bubble
  5. otherwise: capture all id_* inputs, with valid = id_valid
- Latency: one cycle from id_* to registered fields. Forwarding and operand muxing are combinational on the registered fields.
- Load-use detection (combinational):
  - stall_req = ex_valid & reg_mem_read & (reg_rd != 0) & id_valid & ((id_rs1_addr == reg_rd) | (id_rs2_addr == reg_rd)).
  - It is masked by flush; hold does not mask it.
- Forwarding, per source operand s (rs1, rs2), with registered index rs_s:
  - If exm_reg_write & exm_rd_addr != 0 & exm_rd_addr == rs_s: use exm_result.
  - Else if wb_reg_write & wb_rd_addr != 0 & wb_rd_addr == rs_s: use wb_result.
  - Else: use the registered register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand outputs:
  - ALUop1 = fwd_rs1.
  - ALUop2 = reg_alu_src ? reg_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always, independent of alu_src.
- Bubbles: a bubble still drives the ALU (ALUctrl 000, zero operands). Only ex_reg_write and ex_mem_read are qualified by ex_valid.
- rst asserted mid-stall clears stall_req on the following cycle.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding exactly as above. stall_req covers load-use only.
- Undefined: no forwarding; fwd_rs* = registered data. stall_req additionally asserts (also masked by flush) whenever the decode slot's rs1 or rs2 (non-zero, id_valid) matches any of:
  - the live EX rd, when it writes;
  - exm_rd_addr, when exm_reg_write;
  - wb_rd_addr, when wb_reg_write.
  Bubble insertion follows the same priority rules. ex_store_data = registered rs2 data.

Test Plan:
- rst held 2 cycles, then released with idle inputs -> ALUop1 = 0, ALUop2 = 0, ALUctrl = 000, ex_valid = 0, stall_req = 0.
- Capture add, id_rs1_data = 5, id_rs2_data = 7, alu_src = 0, alu_ctrl = 000 -> next cycle ALUop1 = 5, ALUop2 = 7, ALUctrl = 000; same with alu_src = 1, imm = -4 -> ALUop2 = 0xFFFFFFFC.
- EX: rs1 = x3. Drive exm_rd = 3 / exm_result = 0x11 and wb_rd = 3 / wb_result = 0x22 -> ALUop1 = 0x11. Drop exm_reg_write -> 0x22. Set rs1 = x0 with exm_rd = 0 -> ALUop1 = registered data.
- Load in EX (rd = x4, mem_read = 1), decode rs2 = x4 -> stall_req = 1 that cycle; next cycle ex_valid = 0, ex_reg_write = 0; stall_req = 0 afterwards.
- flush and hold asserted together with a valid decode -> next cycle ex_valid = 0. hold alone -> all outputs unchanged across 3 cycles.
- Without EX_FORWARD_EN: wb_rd = 6 writing, decode rs1 = x6 -> stall_req = 1. With the macro -> stall_req = 0 and ALUop1 = wb_result.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register for the RV32I core. It feeds ALUop1, ALUop2 and
// ALUctrl to the ALU, forwards results from EX/MEM and MEM/WB, and inserts
// a bubble when the decode slot has to wait.
// Build option: define EX_FORWARD_EN to enable operand forwarding. Without
// it, the stage reads register-file data only and stalls decode until every
// in-flight writer of its sources has retired.
module ex_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [2:0]            id_alu_ctrl,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] exm_rd_addr,
    input  logic                  exm_reg_write,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_valid,
    output logic                  stall_req
);

    // Source indices are only kept when forwarding needs them.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] imm;
`ifdef EX_FORWARD_EN
        logic [ADDR_WIDTH-1:0] rs1_addr;
        logic [ADDR_WIDTH-1:0] rs2_addr;
`endif
        logic [ADDR_WIDTH-1:0] rd;
        logic [2:0]            alu_ctrl;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_read;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, id_fields;
    logic    load_use;
    logic    dep_hazard;
    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

    // Pack the decode-slot inputs into the register layout.
    always_comb begin
        id_fields           = '0;
        id_fields.valid     = id_valid;
        id_fields.rs1_data  = id_rs1_data;
        id_fields.rs2_data  = id_rs2_data;
        id_fields.imm       = id_imm;
`ifdef EX_FORWARD_EN
        id_fields.rs1_addr  = id_rs1_addr;
        id_fields.rs2_addr  = id_rs2_addr;
`endif
        id_fields.rd        = id_rd_addr;
        id_fields.alu_ctrl  = id_alu_ctrl;
        id_fields.alu_src   = id_alu_src;
        id_fields.reg_write = id_reg_write;
        id_fields.mem_read  = id_mem_read;
    end

    // A load in EX cannot forward its data in time for the instruction behind it.
    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                      ((id_rs1_addr == ex_q.rd) | (id_rs2_addr == ex_q.rd));

`ifdef EX_FORWARD_EN
    assign dep_hazard = 1'b0;

    // EX/MEM is the younger writer, so it wins over MEM/WB; x0 is never forwarded.
    assign fwd_rs1 = (exm_reg_write & (exm_rd_addr != '0) & (exm_rd_addr == ex_q.rs1_addr)) ? exm_result :
                     (wb_reg_write  & (wb_rd_addr  != '0) & (wb_rd_addr  == ex_q.rs1_addr)) ? wb_result  :
                     ex_q.rs1_data;
    assign fwd_rs2 = (exm_reg_write & (exm_rd_addr != '0) & (exm_rd_addr == ex_q.rs2_addr)) ? exm_result :
                     (wb_reg_write  & (wb_rd_addr  != '0) & (wb_rd_addr  == ex_q.rs2_addr)) ? wb_result  :
                     ex_q.rs2_data;
`else
    // Without forwarding, any pending writer of a decode source blocks decode.
    function automatic logic src_pending(input logic [ADDR_WIDTH-1:0] rs,
                                         input logic ex_wr, input logic [ADDR_WIDTH-1:0] ex_rd,
                                         input logic m_wr,  input logic [ADDR_WIDTH-1:0] m_rd,
                                         input logic w_wr,  input logic [ADDR_WIDTH-1:0] w_rd);
        src_pending = (rs != '0) &
                      ((ex_wr & (rs == ex_rd)) | (m_wr & (rs == m_rd)) | (w_wr & (rs == w_rd)));
    endfunction

    assign dep_hazard = id_valid &
        (src_pending(id_rs1_addr, ex_q.valid & ex_q.reg_write, ex_q.rd,
                     exm_reg_write, exm_rd_addr, wb_reg_write, wb_rd_addr) |
         src_pending(id_rs2_addr, ex_q.valid & ex_q.reg_write, ex_q.rd,
                     exm_reg_write, exm_rd_addr, wb_reg_write, wb_rd_addr));

    assign fwd_rs1 = ex_q.rs1_data;
    assign fwd_rs2 = ex_q.rs2_data;

    // Result buses have no consumer in this build.
    logic unused_results;
    assign unused_results = ^{exm_result, wb_result};
`endif

    // A flush kills the decode slot as well, so it never needs to wait.
    assign stall_req = ~flush & (load_use | dep_hazard);

    // Next-state: flush beats hold, hold beats stall, otherwise capture decode.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (stall_req) begin
            ex_d = '0;
        end else begin
            ex_d = id_fields;
        end
    end

    // Pipeline register; reset clears every field including valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Bubbles still drive the ALU with zeroed fields; only side effects are qualified.
    assign ALUop1        = fwd_rs1;
    assign ALUop2        = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign ALUctrl       = ex_q.alu_ctrl;
    assign ex_store_data = fwd_rs2;
    assign ex_rd_addr    = ex_q.rd;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_valid      = ex_q.valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow EX_FORWARD_EN
// when the macro is defined for the build.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [2:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_write, id_mem_read;
    logic        hold, flush;
    logic [4:0]  exm_rd_addr, wb_rd_addr;
    logic        exm_reg_write, wb_reg_write;
    logic [31:0] exm_result, wb_result;
    logic [31:0] ALUop1, ALUop2, ex_store_data;
    logic [2:0]  ALUctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_valid, stall_req;

    int vectors = 0;
    int miscompares = 0;

    ex_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .hold(hold), .flush(flush),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_valid(ex_valid), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_ctrl = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0;
        hold = 0; flush = 0;
        exm_rd_addr = 0; exm_reg_write = 0; exm_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic decode(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [2:0] ctrl, input logic src, input logic rw, input logic mr);
        id_valid = 1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_ctrl = ctrl;
        id_alu_src = src; id_reg_write = rw; id_mem_read = mr;
    endtask

    initial begin
        // Reset held two cycles, released with idle inputs
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_op1", ALUop1, 32'h0);
        chk("rst_op2", ALUop2, 32'h0);
        chk("rst_ctrl", {29'd0, ALUctrl}, 32'h0);
        chk("rst_valid", {31'd0, ex_valid}, 32'h0);
        chk("rst_stall", {31'd0, stall_req}, 32'h0);
        chk("rst_store", ex_store_data, 32'h0);
        chk("rst_rd", {27'd0, ex_rd_addr}, 32'h0);
        chk("rst_rw", {31'd0, ex_reg_write}, 32'h0);
        chk("rst_mr", {31'd0, ex_mem_read}, 32'h0);

        // Register operand capture
        decode(5'd1, 5'd2, 5'd7, 32'd5, 32'd7, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        #1 chk("add_nostall", {31'd0, stall_req}, 32'h0);
        tick();
        chk("add_op1", ALUop1, 32'd5);
        chk("add_op2", ALUop2, 32'd7);
        chk("add_ctrl", {29'd0, ALUctrl}, 32'h0);
        chk("add_valid", {31'd0, ex_valid}, 32'h1);
        chk("add_rw", {31'd0, ex_reg_write}, 32'h1);
        chk("add_rd", {27'd0, ex_rd_addr}, 32'd7);

        // Immediate operand
        decode(5'd1, 5'd2, 5'd8, 32'd5, 32'd7, 32'hFFFF_FFFC, 3'b010, 1'b1, 1'b1, 1'b0);
        tick();
        chk("imm_op2", ALUop2, 32'hFFFF_FFFC);
        chk("imm_ctrl", {29'd0, ALUctrl}, 32'h2);
        chk("imm_store", ex_store_data, 32'd7);

        // rs1 = x3 in EX, writers on both downstream stages
        decode(5'd3, 5'd0, 5'd9, 32'h33, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        id_valid = 0;
        exm_rd_addr = 5'd3; exm_reg_write = 1; exm_result = 32'h11;
        wb_rd_addr = 5'd3; wb_reg_write = 1; wb_result = 32'h22;
`ifdef EX_FORWARD_EN
        #1 chk("fwd_exm", ALUop1, 32'h11);
        exm_reg_write = 0;
        #1 chk("fwd_wb", ALUop1, 32'h22);
        exm_reg_write = 1;
        id_valid = 1; id_rs1_addr = 5'd3;
        #1 chk("fwd_nostall", {31'd0, stall_req}, 32'h0);
`else
        #1 chk("nofwd_exm", ALUop1, 32'h33);
        exm_reg_write = 0;
        #1 chk("nofwd_wb", ALUop1, 32'h33);
        exm_reg_write = 1;
        id_valid = 1; id_rs1_addr = 5'd3;
        #1 chk("nofwd_exm_stall", {31'd0, stall_req}, 32'h1);
`endif

        // x0 is never forwarded
        decode(5'd0, 5'd0, 5'd10, 32'h44, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        exm_rd_addr = 5'd0; exm_reg_write = 1; exm_result = 32'h55;
        wb_reg_write = 0;
        tick();
        chk("x0_op1", ALUop1, 32'h44);
        exm_reg_write = 0;

        // Load-use: load x4 in EX, decode reads x4 as rs2
        decode(5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1);
        tick();
        chk("ld_mr", {31'd0, ex_mem_read}, 32'h1);
        decode(5'd5, 5'd4, 5'd11, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        #1 chk("lu_stall", {31'd0, stall_req}, 32'h1);
        tick();
        chk("lu_bub_valid", {31'd0, ex_valid}, 32'h0);
        chk("lu_bub_rw", {31'd0, ex_reg_write}, 32'h0);
        chk("lu_bub_mr", {31'd0, ex_mem_read}, 32'h0);
        chk("lu_after", {31'd0, stall_req}, 32'h0);
        tick();
        chk("lu_issue_valid", {31'd0, ex_valid}, 32'h1);
        chk("lu_issue_rd", {27'd0, ex_rd_addr}, 32'd11);

        // flush and hold together kill the slot
        decode(5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        flush = 1; hold = 1;
        tick();
        chk("fh_valid", {31'd0, ex_valid}, 32'h0);
        chk("fh_rw", {31'd0, ex_reg_write}, 32'h0);
        flush = 0; hold = 0;

        // Stall masking by flush, not by hold; reset clears a pending stall
        decode(5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1);
        tick();
        decode(5'd12, 5'd0, 5'd13, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        flush = 1;
        #1 chk("stall_flush_mask", {31'd0, stall_req}, 32'h0);
        flush = 0;
        #1 chk("stall_unmasked", {31'd0, stall_req}, 32'h1);
        hold = 1;
        #1 chk("stall_hold", {31'd0, stall_req}, 32'h1);
        tick();
        chk("hold_keeps_load", {31'd0, ex_mem_read}, 32'h1);
        chk("stall_held", {31'd0, stall_req}, 32'h1);
        rst = 1; hold = 0;
        tick();
        rst = 0;
        chk("rst_mid_valid", {31'd0, ex_valid}, 32'h0);
        chk("rst_mid_stall", {31'd0, stall_req}, 32'h0);

        // hold alone freezes every output
        decode(5'd1, 5'd2, 5'd13, 32'hA, 32'hB, 32'h0, 3'b101, 1'b0, 1'b1, 1'b0);
        tick();
        hold = 1;
        decode(5'd1, 5'd2, 5'd14, 32'hFF, 32'hEE, 32'h0, 3'b111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_op1", ALUop1, 32'hA);
            chk("hold_op2", ALUop2, 32'hB);
            chk("hold_ctrl", {29'd0, ALUctrl}, 32'h5);
            chk("hold_rd", {27'd0, ex_rd_addr}, 32'd13);
            chk("hold_valid", {31'd0, ex_valid}, 32'h1);
        end
        hold = 0;

        // MEM/WB writer of decode rs1 = x6
        decode(5'd6, 5'd0, 5'd15, 32'h60, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        wb_rd_addr = 5'd6; wb_reg_write = 1; wb_result = 32'h66;
`ifdef EX_FORWARD_EN
        #1 chk("wb6_stall", {31'd0, stall_req}, 32'h0);
        tick();
        chk("wb6_op1", ALUop1, 32'h66);
`else
        #1 chk("wb6_stall", {31'd0, stall_req}, 32'h1);
        wb_reg_write = 0;
        #1 chk("wb6_clear", {31'd0, stall_req}, 32'h0);
        tick();
        chk("wb6_op1", ALUop1, 32'h60);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
